// File: rtl/trig_pulse_sync.sv
// trig_pulse_sync: synchronizes async trigger pulses, emits dead-timed hit strobes, counts hits
module trig_pulse_sync #(
  parameter int WIDTH = 48,
  parameter int DEAD  = 4,
  parameter int CNT_W = 16,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pulse_n,
  input  logic [WIDTH-1:0] enable,
  input  logic             clr_cnt,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] hit,
  output logic [WIDTH-1:0] busy,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_valid
);
  localparam logic [7:0] DEAD_V = 8'(DEAD);
  logic [WIDTH-1:0] s1, s2, s3, acc;
  logic [7:0]       dead [WIDTH];
  logic [CNT_W-1:0] cnt  [WIDTH];
  logic [1:0]       arm_cnt;
  logic             armed;
  // busy mirrors dead!=0, so it stands in for the dead-time test
  assign acc = s2 & ~s3 & enable & ~busy & {WIDTH{armed}};
  // synchronizer, arm delay, hit strobes, dead-time and hit counters
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      hit <= '0;
      busy <= '0;
      arm_cnt <= '0;
      armed <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        dead[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      s1 <= ~pulse_n;
      s2 <= s1;
      s3 <= s2;
      hit <= acc;
      if (!armed) begin
        arm_cnt <= arm_cnt + 2'd1;
        armed <= arm_cnt == 2'd2;
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (acc[i]) begin
          dead[i] <= DEAD_V;
          busy[i] <= 1'b1;
        end else if (busy[i]) begin
          dead[i] <= dead[i] - 8'd1;
          busy[i] <= dead[i] != 8'd1;
        end
        if (clr_cnt) cnt[i] <= '0;
        else if (acc[i] && !(&cnt[i])) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
  // one-cycle read port; out-of-range channels read as zero
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= (32'(rd_addr) < WIDTH) ? cnt[rd_addr] : '0;
    end
  end
endmodule

// File: tb/tb_trig_pulse_sync.sv
// tb_trig_pulse_sync: directed checks of hit timing, dead time, counters, read port and reset
module tb_trig_pulse_sync;
  logic        clk = 0;
  logic        reset = 1;
  logic [47:0] pulse_n = '1;
  logic [47:0] enable = '1;
  logic        clr_cnt = 0;
  logic        rd_req = 0;
  logic [5:0]  rd_addr = '0;
  logic [47:0] hit, busy;
  logic [3:0]  rd_data;
  logic        rd_valid;
  int passed = 0, total = 0;
  int hits [48];
  int base;

  trig_pulse_sync #(.WIDTH(48), .DEAD(4), .CNT_W(4), .AW(6)) dut (
    .clk(clk), .reset(reset), .pulse_n(pulse_n), .enable(enable), .clr_cnt(clr_cnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .hit(hit), .busy(busy), .rd_data(rd_data),
    .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) for (int i = 0; i < 48; i++) hits[i] += int'(hit[i]);

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic pl(input logic [47:0] m, input int low, input int gap);
    pulse_n = pulse_n & ~m;
    step(low);
    pulse_n = pulse_n | m;
    step(gap);
  endtask

  task automatic rd(input string tag, input logic [5:0] a, input logic [3:0] exp);
    rd_addr = a;
    rd_req = 1;
    step(1);
    rd_req = 0;
    chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
    chk({tag, "_data"}, 64'(rd_data), 64'(exp));
  endtask

  initial begin
    step(2);
    chk("rst_hit", 64'(hit), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_data", 64'(rd_data), 64'd0);
    reset = 0;
    step(4);
    // single pulse on channel 3, low across two edges
    pulse_n[3] = 0;
    step(2);
    chk("p3_early", 64'(hit), 64'd0);
    pulse_n[3] = 1;
    step(1);
    chk("p3_hit", 64'(hit), 64'h8);
    chk("p3_busy0", 64'(busy), 64'h8);
    step(1);
    chk("p3_hit_off", 64'(hit), 64'd0);
    for (int i = 1; i < 4; i++) begin
      chk("p3_busy", 64'(busy), 64'h8);
      step(1);
    end
    chk("p3_busy_end", 64'(busy), 64'd0);
    step(4);
    rd("p3_rd", 6'd3, 4'd1);
    step(1);
    chk("rd_idle_valid", 64'(rd_valid), 64'd0);
    chk("rd_hold", 64'(rd_data), 64'd1);
    // dead time on channel 0
    base = hits[0];
    pl(48'h1, 1, 2);
    pl(48'h1, 1, 10);
    chk("dead_close", 64'(hits[0] - base), 64'd1);
    pl(48'h1, 1, 5);
    pl(48'h1, 1, 10);
    chk("dead_far", 64'(hits[0] - base), 64'd3);
    rd("dead_rd", 6'd0, 4'd3);
    // masked channel and held level
    enable[5] = 0;
    base = hits[5];
    pl(48'h20, 2, 8);
    enable[5] = 1;
    step(4);
    chk("mask_hits", 64'(hits[5] - base), 64'd0);
    rd("mask_rd", 6'd5, 4'd0);
    base = hits[7];
    pl(48'h80, 20, 8);
    chk("hold_hits", 64'(hits[7] - base), 64'd1);
    rd("hold_rd", 6'd7, 4'd1);
    // saturation on channel 1
    base = hits[1];
    for (int i = 0; i < 20; i++) pl(48'h2, 1, 7);
    chk("sat_hits", 64'(hits[1] - base), 64'd20);
    rd("sat_rd", 6'd1, 4'd15);
    // clear together with a hit
    pulse_n[1] = 0;
    step(1);
    pulse_n[1] = 1;
    step(1);
    clr_cnt = 1;
    step(1);
    clr_cnt = 0;
    chk("clr_hit", 64'(hit), 64'h2);
    step(6);
    rd("clr_rd1", 6'd1, 4'd0);
    rd("clr_rd0", 6'd0, 4'd0);
    // all pulses low through reset release
    pulse_n = '0;
    reset = 1;
    step(3);
    reset = 0;
    base = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (hit != 0) base++;
    end
    chk("arm_nohit", 64'(base), 64'd0);
    pulse_n = '1;
    step(4);
    // simultaneous hits on all channels, then reset mid-dead-time with a read pending
    pl('1, 1, 2);
    chk("all_hit", 64'(hit), 64'hFFFF_FFFF_FFFF);
    step(1);
    chk("all_busy", 64'(busy), 64'hFFFF_FFFF_FFFF);
    rd_req = 1;
    rd_addr = 6'd0;
    reset = 1;
    step(1);
    rd_req = 0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_valid", 64'(rd_valid), 64'd0);
    chk("midrst_data", 64'(rd_data), 64'd0);
    reset = 0;
    step(4);
    // counts 1,2,3 on channels 0,1,2, then out-of-range and back-to-back reads
    pl(48'h4, 1, 7);
    pl(48'h6, 1, 7);
    pl(48'h7, 1, 7);
    rd_req = 1;
    rd_addr = 6'd50;
    step(1);
    chk("oor_valid", 64'(rd_valid), 64'd1);
    chk("oor_data", 64'(rd_data), 64'd0);
    rd_addr = 6'd0;
    step(1);
    chk("b2b0", 64'(rd_data), 64'd1);
    rd_addr = 6'd1;
    step(1);
    chk("b2b1", 64'(rd_data), 64'd2);
    rd_addr = 6'd2;
    step(1);
    chk("b2b2", 64'(rd_data), 64'd3);
    chk("b2b_valid", 64'(rd_valid), 64'd1);
    rd_req = 0;
    step(1);
    chk("b2b_end_valid", 64'(rd_valid), 64'd0);
    chk("b2b_end_hold", 64'(rd_data), 64'd3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
